// File: rtl/hacd_pkg.sv
// HACD shared types: HAWK override/request packets and the read-stall FSM states.
// AXI4 width macros fall back to local defaults when the build does not supply them.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 48
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 4
`endif

package hacd_pkg;

  localparam int HACD_ADDR_W = `HACD_AXI4_ADDR_WIDTH;
  localparam int HACD_PAGE_W = HACD_ADDR_W - 12;

  typedef struct packed {
    logic                   allow_access;
    logic [HACD_ADDR_W-1:0] ppa;
  } hawk_cpu_ovrd_pkt_t;

  typedef struct packed {
    logic                   valid;
    logic [HACD_PAGE_W-1:0] hppa;
  } cpu_reqpkt_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GRANT = 2'd1,
    ISSUE      = 2'd2,
    DATA       = 2'd3
  } hawk_rd_stall_state_e;

endpackage

// File: rtl/hawk_rd_rfifo.sv
// Synchronous FIFO for returned R beats; the head entry is read combinationally,
// so a beat pushed on one edge is visible at the output one cycle later.
module hawk_rd_rfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hawk_cpu_stall_rd.sv
// Holds each CPU AR until HAWK grants (optionally overriding the page) or is inactive, then forwards it.
// Optional grant-wait timeout under HACD_RD_STALL_TIMEOUT_EN; R beats return through hawk_rd_rfifo.
module hawk_cpu_stall_rd
  import hacd_pkg::*;
#(
  parameter int DATA_WIDTH     = `HACD_AXI4_DATA_WIDTH,
  parameter int ADDR_WIDTH     = `HACD_AXI4_ADDR_WIDTH,
  parameter int ID_WIDTH       = `HACD_AXI4_ID_WIDTH,
  parameter int USER_WIDTH     = `HACD_AXI4_USER_WIDTH,
  parameter int RFIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  hawk_cpu_ovrd_pkt_t    hawk_cpu_ovrd_pkt,
  output cpu_reqpkt_t           cpu_reqpkt,
  input  logic                  hawk_inactive,
  output logic                  stall_timeout,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [3:0]            s_axi_arregion,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic [USER_WIDTH-1:0] s_axi_ruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic [USER_WIDTH-1:0] m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic [USER_WIDTH-1:0] m_axi_ruser,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int RW = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

  hawk_rd_stall_state_e state, state_d;
  logic ar_hs, grant, r_push, r_pop, tmo_hit, fifo_full, fifo_empty;
  logic unused_ppa_lo;

  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign grant         = hawk_cpu_ovrd_pkt.allow_access && !hawk_inactive;
  assign r_push        = m_axi_rvalid && m_axi_rready;
  assign r_pop         = s_axi_rvalid && s_axi_rready;
  assign unused_ppa_lo = ^hawk_cpu_ovrd_pkt.ppa[11:0];

  assign cpu_reqpkt.valid = (state == WAIT_GRANT);
  assign cpu_reqpkt.hppa  = HACD_PAGE_W'(m_axi_araddr[ADDR_WIDTH-1:12]);

`ifdef HACD_RD_STALL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;

  // Fail-open: a grant or bypass arriving on the last cycle still wins.
  assign tmo_hit = (state == WAIT_GRANT) && !grant && !hawk_inactive &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign stall_timeout = tmo_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (ar_hs)                    tmo_cnt <= '0;
      else if (state == WAIT_GRANT) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) tmo_flag <= 1'b1;
    end
  end
`else
  localparam int tmo_cfg_unused = TIMEOUT_CYCLES;
  assign tmo_hit       = 1'b0;
  assign stall_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:       if (ar_hs) state_d = WAIT_GRANT;
      WAIT_GRANT: if (grant || hawk_inactive || tmo_hit) state_d = ISSUE;
      ISSUE:      if (m_axi_arvalid && m_axi_arready) state_d = DATA;
      DATA:       if (r_push && m_axi_rlast) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      s_axi_arready  <= 1'b0;
      m_axi_arvalid  <= 1'b0;
      m_axi_arid     <= '0;
      m_axi_araddr   <= '0;
      m_axi_arlen    <= '0;
      m_axi_arsize   <= '0;
      m_axi_arburst  <= '0;
      m_axi_arlock   <= 1'b0;
      m_axi_arcache  <= '0;
      m_axi_arprot   <= '0;
      m_axi_arqos    <= '0;
      m_axi_arregion <= '0;
      m_axi_aruser   <= '0;
    end else begin
      state         <= state_d;
      s_axi_arready <= (state_d == IDLE);
      m_axi_arvalid <= (state_d == ISSUE);
      if (ar_hs) begin
        m_axi_arid     <= s_axi_arid;
        m_axi_araddr   <= s_axi_araddr;
        m_axi_arlen    <= s_axi_arlen;
        m_axi_arsize   <= s_axi_arsize;
        m_axi_arburst  <= s_axi_arburst;
        m_axi_arlock   <= s_axi_arlock;
        m_axi_arcache  <= s_axi_arcache;
        m_axi_arprot   <= s_axi_arprot;
        m_axi_arqos    <= s_axi_arqos;
        m_axi_arregion <= s_axi_arregion;
        m_axi_aruser   <= s_axi_aruser;
      end else if (state == WAIT_GRANT && grant) begin
        m_axi_araddr <= {hawk_cpu_ovrd_pkt.ppa[ADDR_WIDTH-1:12], m_axi_araddr[11:0]};
      end
    end
  end

  // rready already low when full, so a push never meets a full FIFO.
  assign m_axi_rready = (state == DATA) && !fifo_full;
  assign s_axi_rvalid = !fifo_empty;

  hawk_rd_rfifo #(
    .WIDTH (RW),
    .DEPTH (RFIFO_DEPTH)
  ) u_rfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_push),
    .push_data ({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser}),
    .pop       (r_pop),
    .pop_data  ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/hawk_cpu_stall_rd.md
Name: hawk_cpu_stall_rd

Overview:
- Read-direction companion to the HAWK CPU write-stall path. It sits between the CPU-side AXI4 read master and the memory-side AXI4 read slave, inside the vtheaplab_hacd chipset logic.
- Each accepted AR request is captured and held while a cpu_reqpkt is presented to HAWK. The AR is forwarded only when HAWK grants access or HAWK is inactive; on a grant the physical page is optionally overridden.
- R beats return through a small FIFO. One read is outstanding at a time.

Parameters:
- DATA_WIDTH, `HACD_AXI4_DATA_WIDTH, R data width.
- ADDR_WIDTH, `HACD_AXI4_ADDR_WIDTH, AR address width; must be >12.
- ID_WIDTH, `HACD_AXI4_ID_WIDTH, AXI ID width.
- USER_WIDTH, `HACD_AXI4_USER_WIDTH, aruser/ruser width.
- RFIFO_DEPTH, 4, R buffer entries; power of two, >=2.
- TIMEOUT_CYCLES, 1024, grant-wait limit; used only with HACD_RD_STALL_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- hawk_cpu_ovrd_pkt  in  hacd_pkg::hawk_cpu_ovrd_pkt_t  grant pulse (.allow_access) and override page (.ppa).
- cpu_reqpkt  out  hacd_pkg::cpu_reqpkt_t  .valid and .hppa = held araddr[ADDR_WIDTH-1:12].
- hawk_inactive  in  1  bypass: forward without a grant, no override.
- stall_timeout  out  1  sticky grant-timeout flag.
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion/aruser  in  AXI widths  CPU AR fields.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid/rdata/rresp/rlast/ruser  out  AXI widths;  s_axi_rvalid  out  1;  s_axi_rready  in  1.
- m_axi_ar*  out  AXI widths  held AR fields;  m_axi_arvalid  out  1;  m_axi_arready  in  1.
- m_axi_rid/rdata/rresp/rlast/ruser  in  AXI widths;  m_axi_rvalid  in  1;  m_axi_rready  out  1.

Behaviour:
- Reset (async assert, sync release): state IDLE; s_axi_arready=0, m_axi_arvalid=0, cpu_reqpkt.valid=0, s_axi_rvalid=0, m_axi_rready=0, stall_timeout=0; FIFO emptied; held AR fields cleared to 0.
- s_axi_arready is registered. It rises in the first cycle after reset release.
- IDLE:
  - s_axi_arready=1.
  - On arvalid&arready, capture all AR fields, drop arready next cycle, go to WAIT_GRANT.
- WAIT_GRANT:
  - cpu_reqpkt.valid=1; hppa is taken from the held address.
  - allow_access=1 and hawk_inactive=0 in the same cycle: held araddr[ADDR_WIDTH-1:12] <= ppa[ADDR_WIDTH-1:12], bits [11:0] unchanged; go to ISSUE.
  - hawk_inactive=1 (regardless of allow_access): no override; go to ISSUE.
  - allow_access pulses in any other state are ignored, not latched.
- ISSUE:
  - m_axi_arvalid=1 (registered) with held fields stable until m_axi_arready.
  - On handshake, drop arvalid next cycle and go to DATA. arvalid never drops without a handshake.
- DATA:
  - m_axi_rready = FIFO not full.
  - Each m-side R handshake pushes {id,data,resp,last,user}.
  - On the m-side handshake with rlast=1, go to IDLE. A new AR may be accepted while older beats are still draining the FIFO.
- R FIFO:
  - s_axi_rvalid = FIFO not empty; push-to-pop latency is 1 cycle.
  - Simultaneous push and pop on a full FIFO is not allowed, because rready is already low when full.
  - Simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.
  - Pointers are FIFO_ADDR_WIDTH+1 bits with an MSB wrap bit; full/empty are derived from the pointer compare.
- arlen is honoured only through rlast; no internal beat count.
- Reset mid-transaction is legal only when the downstream slave is reset together with this block; in-flight beats are discarded.

Optional Feature:
- Macro: HACD_RD_STALL_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to WAIT_GRANT and increments each WAIT_GRANT cycle.
  - At TIMEOUT_CYCLES without a grant: set stall_timeout (sticky until rst) and go to ISSUE with no override (fail-open).
- Not defined: stall_timeout is tied 0 and WAIT_GRANT waits indefinitely.

Decomposition:
- hacd_pkg (existing) supplies hawk_cpu_ovrd_pkt_t and cpu_reqpkt_t.
- Add to hacd_pkg: state enum hawk_rd_stall_state_e {IDLE, WAIT_GRANT, ISSUE, DATA}.
- One sub-module: hawk_rd_rfifo, a parameterised synchronous FIFO with WIDTH and DEPTH, async reset, and full/empty outputs.

Test Plan:
- Grant with override: AR araddr=0x0000_1234_5ABC, allow_access pulse with ppa=0x0000_0009_9000 after 5 cycles -> cpu_reqpkt.valid high 5 cycles, hppa=0x12345; m_axi_araddr=0x0000_0009_9ABC.
- Inactive bypass: hawk_inactive=1 on the same cycle as allow_access=1 -> araddr forwarded unchanged, 1 cycle after entering WAIT_GRANT.
- Burst with backpressure: arlen=3, s_axi_rready=0 for 10 cycles -> m_axi_rready drops after RFIFO_DEPTH beats; all 4 beats delivered in order, rlast on beat 4; state returns to IDLE.
- Stray grant: allow_access pulse in IDLE, then AR accepted -> remains in WAIT_GRANT until a new pulse arrives.
- Async reset in ISSUE -> m_axi_arvalid=0 immediately with no clock edge needed; s_axi_arready=1 in the first cycle after release.
- Timeout (macro defined, TIMEOUT_CYCLES=16): no grant -> stall_timeout=1 and m_axi_arvalid asserted after 16 WAIT_GRANT cycles; address unmodified.
